// File: rtl/vga_pkg.sv
// Shared VGA types and constants: arbiter state encoding, the default hblank
// write budget, and an index-width helper.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    HBLANK,
    VBLANK
  } arb_state_t;

  localparam int HB_BUDGET_DEFAULT = 8;

  // Width of an index into n ports; a single port still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// to winner+1 whenever a grant is issued.
module rr_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] ptr;

  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    int idx;
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (enable && !valid && req[idx]) begin
        valid      = 1'b1;
        winner     = IDX_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (valid) begin
      ptr <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port frame memory arbiter: display reads always win, and writes use only blanking.
// RD_LAT counts edges from read issue to disp_data; mem_rdata is valid the cycle before disp_valid.
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 12,
  parameter int RD_LAT    = 1,
  parameter int HB_BUDGET = HB_BUDGET_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hblnk,
  input  logic                    vblnk,
  input  logic                    disp_req,
  input  logic [ADDR_W-1:0]       disp_addr,
  output logic [DATA_W-1:0]       disp_data,
  output logic                    disp_valid,
  input  logic [N_REQ-1:0]        wr_req,
  input  logic [N_REQ*ADDR_W-1:0] wr_addr,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  output logic [N_REQ-1:0]        wr_ack,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    frame_start
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int BUD_W = $clog2(HB_BUDGET + 1);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [BUD_W-1:0] budget_q;
  logic [BUD_W-1:0] budget_eff;
  logic             write_ok;
  logic             vblnk_q;
  logic [RD_LAT:0]  rd_pipe;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] winner;
  logic             gnt_valid;
  logic [N_REQ-1:0] req_live;

  // State follows this cycle's blanking inputs; the budget reloads on HBLANK entry.
  always_comb begin
    state_d    = ACTIVE;
    budget_eff = budget_q;
    if (vblnk) begin
      state_d = VBLANK;
    end else if (hblnk) begin
      state_d = HBLANK;
      if (state_q != HBLANK) budget_eff = BUD_W'(HB_BUDGET);
    end
  end

  assign write_ok = (state_d == VBLANK) || ((state_d == HBLANK) && (budget_eff != '0));

  // A writer still shows its old request in its ack cycle, so mask it there to avoid a second grant.
  assign req_live = wr_req & ~wr_ack;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_live),
    .enable (write_ok && !disp_req),
    .grant  (grant),
    .winner (winner),
    .valid  (gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACTIVE;
      budget_q    <= '0;
      vblnk_q     <= 1'b0;
      frame_start <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wr_ack      <= '0;
      rd_pipe     <= '0;
      disp_data   <= '0;
    end else begin
      state_q     <= state_d;
      budget_q    <= ((state_d == HBLANK) && gnt_valid) ? budget_eff - BUD_W'(1) : budget_eff;
      vblnk_q     <= vblnk;
      frame_start <= vblnk & ~vblnk_q;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      wr_ack      <= '0;
      if (disp_req) begin
        mem_en   <= 1'b1;
        mem_addr <= disp_addr;
      end else if (gnt_valid) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr[int'(winner)*ADDR_W +: ADDR_W];
        mem_wdata <= wr_data[int'(winner)*DATA_W +: DATA_W];
        wr_ack    <= grant;
      end
      rd_pipe <= {rd_pipe[RD_LAT-1:0], disp_req};
      if (rd_pipe[RD_LAT-1]) disp_data <= mem_rdata;
    end
  end

  assign disp_valid = rd_pipe[RD_LAT];

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed and randomized bench for vga_mem_arbiter against a
// transaction-level reference model and a small behavioural memory.
module tb_vga_mem_arbiter;

  localparam int N_REQ     = 2;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 12;
  localparam int RD_LAT    = 1;
  localparam int HB_BUDGET = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    hblnk;
  logic                    vblnk;
  logic                    disp_req;
  logic [ADDR_W-1:0]       disp_addr;
  logic [DATA_W-1:0]       disp_data;
  logic                    disp_valid;
  logic [N_REQ-1:0]        wr_req;
  logic [N_REQ*ADDR_W-1:0] wr_addr;
  logic [N_REQ*DATA_W-1:0] wr_data;
  logic [N_REQ-1:0]        wr_ack;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    frame_start;

  always #5 clk = ~clk;

  vga_mem_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .HB_BUDGET(HB_BUDGET)
  ) dut (
    .clk(clk), .rst(rst), .hblnk(hblnk), .vblnk(vblnk),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .frame_start(frame_start)
  );

  // Memory aliased on the low address byte; combinational read for RD_LAT=1.
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  typedef struct { int due; logic [DATA_W-1:0] data; } rd_t;
  rd_t               rdq[$];
  logic [DATA_W-1:0] ref_mem [0:255];
  int                edge_n   = 0;
  int                m_ptr    = 0;
  int                m_budget = 0;
  bit                m_in_hb  = 0;
  bit                m_vq     = 0;
  logic [N_REQ-1:0]  pending  = '0;
  logic [N_REQ-1:0]  ack_prev = '0;
  int                wr_prob [N_REQ];

  logic              exp_en, exp_we, exp_valid, exp_fs;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata, exp_data;
  logic [N_REQ-1:0]  exp_ack;

  // Predict what the DUT shows after the coming edge, from the inputs now applied.
  task automatic model_edge();
    bit found;
    rd_t r;
    edge_n++;
    exp_en = 0; exp_we = 0; exp_ack = '0; exp_valid = 0;
    if (rst) begin
      m_ptr = 0; m_budget = 0; m_in_hb = 0; m_vq = 0;
      exp_fs = 0; exp_addr = '0; exp_wdata = '0; exp_data = '0;
      rdq.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      return;
    end
    exp_fs = vblnk && !m_vq;
    m_vq   = vblnk;
    if (!vblnk && hblnk) begin
      if (!m_in_hb) m_budget = HB_BUDGET;
      m_in_hb = 1;
    end else begin
      m_in_hb = 0;
    end
    if (rdq.size() > 0 && rdq[0].due == edge_n) begin
      exp_valid = 1;
      exp_data  = rdq[0].data;
      void'(rdq.pop_front());
    end
    if (disp_req) begin
      exp_en   = 1;
      exp_addr = disp_addr;
      r.due    = edge_n + RD_LAT;
      r.data   = ref_mem[disp_addr[7:0]];
      rdq.push_back(r);
    end else if (vblnk || (m_in_hb && m_budget > 0)) begin
      found = 0;
      for (int k = 0; k < N_REQ; k++) begin
        int w;
        w = (m_ptr + k) % N_REQ;
        if (!found && wr_req[w] && pending[w]) begin
          found      = 1;
          exp_en     = 1;
          exp_we     = 1;
          exp_addr   = wr_addr[w*ADDR_W +: ADDR_W];
          exp_wdata  = wr_data[w*DATA_W +: DATA_W];
          exp_ack[w] = 1'b1;
          pending[w] = 1'b0;
          m_ptr      = (w + 1) % N_REQ;
          if (!vblnk) m_budget--;
          ref_mem[exp_addr[7:0]] = exp_wdata;
        end
      end
    end
  endtask

  task automatic load_txn(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_addr[i*ADDR_W +: ADDR_W] = a;
    wr_data[i*DATA_W +: DATA_W] = d;
    wr_req[i]  = 1'b1;
    pending[i] = 1'b1;
  endtask

  // Random writes keep the low address byte at 0x10 or above, clear of the preloaded cells.
  task automatic new_txn(input int i);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom);
    if (a[7:0] < 8'h10) a[7:4] = 4'h1;
    load_txn(i, a, DATA_W'($urandom));
  endtask

  // Writers hold through their ack cycle, then move on the cycle after.
  task automatic agents();
    for (int i = 0; i < N_REQ; i++) begin
      if (ack_prev[i] || !wr_req[i]) begin
        if (int'($urandom_range(99)) < wr_prob[i]) new_txn(i);
        else wr_req[i] = 1'b0;
      end
    end
    ack_prev = exp_ack;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("mem_en",      32'(mem_en),      32'(exp_en));
    check("mem_we",      32'(mem_we),      32'(exp_we));
    check("mem_addr",    32'(mem_addr),    32'(exp_addr));
    check("mem_wdata",   32'(mem_wdata),   32'(exp_wdata));
    check("wr_ack",      32'(wr_ack),      32'(exp_ack));
    check("disp_valid",  32'(disp_valid),  32'(exp_valid));
    check("disp_data",   32'(disp_data),   32'(exp_data));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    agents();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_we, cnt_ack;
    rst = 1; hblnk = 0; vblnk = 0; disp_req = 0; disp_addr = '0;
    wr_req = '0; wr_addr = '0; wr_data = '0;
    wr_prob[0] = 0; wr_prob[1] = 0;
    repeat (3) tick();
    rst = 0;
    tick();

    // Read issued, then reset arrives before its data returns.
    disp_req = 1; disp_addr = 16'h0055;
    tick();
    rst = 1; disp_req = 0;
    tick();
    check("rst_mid_valid", 32'(disp_valid), 32'(0));
    check("rst_mid_en",    32'(mem_en),     32'(0));
    check("rst_mid_addr",  32'(mem_addr),   32'(0));
    check("rst_mid_ack",   32'(wr_ack),     32'(0));
    rst = 0;
    tick();
    check("rst_after_valid", 32'(disp_valid), 32'(0));

    // Active video: writers wait however long they request.
    wr_prob[0] = 100; wr_prob[1] = 100;
    cnt_we = 0; cnt_ack = 0;
    repeat (100) begin
      tick();
      cnt_we  += int'(mem_we);
      cnt_ack += int'(wr_ack != '0);
    end
    check("active_we_cnt",  32'(cnt_we),  32'(0));
    check("active_ack_cnt", 32'(cnt_ack), 32'(0));

    // Vertical blank: both writers alternate starting from port 0.
    vblnk = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("vb_alt_ack", 32'(wr_ack), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("vb_alt_we",  32'(mem_we), 32'(1));
    end

    // Drain writers, then preload three cells through writer 0.
    wr_prob[0] = 0; wr_prob[1] = 0;
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      load_txn(0, 16'h0100 + 16'(k), 12'h0A1 + 12'(k));
      for (int t = 0; t < 10 && pending[0]; t++) tick();
      check("preload_grant", 32'(pending[0]), 32'(0));
      repeat (2) tick();
    end

    // Three back-to-back reads in vblank while both writers request.
    wr_prob[0] = 100; wr_prob[1] = 100;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      disp_req  = (k < 3);
      disp_addr = 16'h0100 + 16'(k);
      tick();
      if (k < 3) begin
        check("rd_blk_ack", 32'(wr_ack), 32'(0));
        check("rd_blk_we",  32'(mem_we), 32'(0));
      end
      if (k > 0) begin
        check("rd_valid", 32'(disp_valid), 32'(1));
        check("rd_data",  32'(disp_data),  32'h0A0 + 32'(k));
      end
    end
    disp_req = 0;

    // Horizontal blank budget: writer 0 alone, 20-cycle hblank.
    wr_prob[1] = 0;
    repeat (4) tick();
    vblnk = 0; hblnk = 0;
    repeat (5) tick();
    hblnk = 1; cnt_ack = 0;
    repeat (20) begin tick(); cnt_ack += int'(wr_ack[0]); end
    check("hb_acks", 32'(cnt_ack), 32'(HB_BUDGET));
    hblnk = 0; cnt_ack = 0;
    repeat (10) begin tick(); cnt_ack += int'(wr_ack != '0); end
    check("post_hb_acks", 32'(cnt_ack), 32'(0));
    hblnk = 1; cnt_ack = 0;
    repeat (6) begin tick(); cnt_ack += int'(wr_ack[0]); end
    check("hb2_acks", 32'(cnt_ack), 32'(3));
    hblnk = 0;

    // frame_start: single pulse after vblnk rises.
    repeat (5) tick();
    vblnk = 1;
    tick();
    check("fs_pulse", 32'(frame_start), 32'(1));
    tick();
    check("fs_clear", 32'(frame_start), 32'(0));

    // Randomized frames: 24-cycle lines, hblank on the last 10, vblank on lines 8-9.
    wr_prob[0] = 60; wr_prob[1] = 60;
    for (int f = 0; f < 5; f++) begin
      for (int l = 0; l < 10; l++) begin
        for (int p = 0; p < 24; p++) begin
          hblnk     = (p >= 14);
          vblnk     = (l >= 8);
          disp_req  = (!hblnk && !vblnk) ? ($urandom_range(99) < 60) : ($urandom_range(99) < 10);
          disp_addr = ADDR_W'($urandom);
          tick();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
